// File: rtl/ex_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_pkg : opcode classes, sub-op codes, flag positions and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package ex_pkg;

  localparam int unsigned c_dopc_inte  = 3;
  localparam int unsigned c_dopc_shift = 2;
  localparam int unsigned c_dopc_logic = 1;
  localparam int unsigned c_dopc_mul   = 0;

  localparam logic [3:0] c_cls_inte  = 4'b0001 << c_dopc_inte;
  localparam logic [3:0] c_cls_shift = 4'b0001 << c_dopc_shift;
  localparam logic [3:0] c_cls_logic = 4'b0001 << c_dopc_logic;
  localparam logic [3:0] c_cls_mul   = 4'b0001 << c_dopc_mul;

  localparam logic [2:0] c_opc_add = 3'd0;
  localparam logic [2:0] c_opc_sub = 3'd1;
  localparam logic [2:0] c_opc_cmp = 3'd2;
  localparam logic [2:0] c_opc_sll = 3'd0;
  localparam logic [2:0] c_opc_srl = 3'd1;
  localparam logic [2:0] c_opc_sra = 3'd2;
  localparam logic [2:0] c_opc_and = 3'd0;
  localparam logic [2:0] c_opc_or  = 3'd1;
  localparam logic [2:0] c_opc_xor = 3'd2;
  localparam logic [2:0] c_opc_mul = 3'd0;

  localparam int unsigned c_flag_z = 3;
  localparam int unsigned c_flag_n = 2;
  localparam int unsigned c_flag_c = 1;
  localparam int unsigned c_flag_v = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ex_mul_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mul_seq : shift-add multiplier, one partial product per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] product
);

  localparam int W_CNT = $clog2(WORD);

  logic [WORD-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[cnt_q]) begin
        acc_d = acc_q + (a_q << cnt_q);
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == W_CNT'(WORD - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the final step; product is complete on the following cycle
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == W_CNT'(WORD - 1));
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_stage_mc : execute stage, 1-cycle ALU plus iterative multiply, flags
// Rev 1.0
// ----------------------------------------------------------------------------
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WORD    = 32,
  parameter int W_RD    = 5,
  parameter int W_ADDR  = 32,
  parameter int W_FLAGS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  output logic               stall_o,
  input  logic [WORD-1:0]    src_i,
  input  logic [WORD-1:0]    dest_i,
  input  logic               wb_i,
  input  logic [W_RD-1:0]    rd_num_i,
  input  logic [3:0]         dopc_i,
  input  logic [2:0]         opc_i,
  input  logic [W_ADDR-1:0]  origaddr_i,
  input  logic               stall_i,
  output logic               v_o,
  output logic               wb_o,
  output logic [W_RD-1:0]    rd_num_o,
  output logic [WORD-1:0]    rd_data_o,
  output logic [W_ADDR-1:0]  origaddr_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam int W_SH = $clog2(WORD);

  state_e             state_q, state_d;
  logic               v_q, v_d, wb_q, wb_d, mwb_q, mwb_d;
  logic [W_RD-1:0]    rd_num_q, rd_num_d, mrd_q, mrd_d;
  logic [WORD-1:0]    rd_data_q, rd_data_d;
  logic [W_ADDR-1:0]  origaddr_q, origaddr_d, maddr_q, maddr_d;
  logic [W_FLAGS-1:0] flags_q, flags_d;

  logic [WORD:0]      w_add, w_sub;
  logic [W_SH-1:0]    w_shamt;
  logic [WORD-1:0]    w_alu_res, w_mul_product;
  logic [W_FLAGS-1:0] w_alu_flags;
  logic               w_alu_wb, w_alu_zn, w_is_mul, w_load, w_accept;
  logic               w_mul_start, w_mul_busy, w_mul_done;

  // sub carry-out is the no-borrow flag
  assign w_add    = {1'b0, dest_i} + {1'b0, src_i};
  assign w_sub    = {1'b0, dest_i} + {1'b0, ~src_i} + {{WORD{1'b0}}, 1'b1};
  assign w_shamt  = src_i[W_SH-1:0];
  assign w_is_mul = (dopc_i == c_cls_mul) && (opc_i == c_opc_mul);

  assign w_load   = !v_q || !stall_i;
  assign stall_o  = (state_q != IDLE) || (v_q && stall_i);
  assign w_accept = v_i && !stall_o;

  always_comb begin
    w_alu_res   = '0;
    w_alu_flags = flags_q;
    w_alu_wb    = wb_i;
    w_alu_zn    = 1'b0;
    case (dopc_i)
      c_cls_inte: begin
        case (opc_i)
          c_opc_add: begin
            w_alu_res             = w_add[WORD-1:0];
            w_alu_flags[c_flag_c] = w_add[WORD];
            w_alu_flags[c_flag_v] = (dest_i[WORD-1] == src_i[WORD-1]) &&
                                    (w_add[WORD-1] != dest_i[WORD-1]);
            w_alu_zn              = 1'b1;
          end
          c_opc_sub, c_opc_cmp: begin
            w_alu_res             = w_sub[WORD-1:0];
            w_alu_flags[c_flag_c] = w_sub[WORD];
            w_alu_flags[c_flag_v] = (dest_i[WORD-1] != src_i[WORD-1]) &&
                                    (w_sub[WORD-1] != dest_i[WORD-1]);
            w_alu_zn              = 1'b1;
            w_alu_wb              = wb_i && (opc_i != c_opc_cmp);
          end
          default: ;
        endcase
      end
      c_cls_shift: begin
        case (opc_i)
          c_opc_sll: begin w_alu_res = dest_i << w_shamt; w_alu_zn = 1'b1; end
          c_opc_srl: begin w_alu_res = dest_i >> w_shamt; w_alu_zn = 1'b1; end
          c_opc_sra: begin w_alu_res = $unsigned($signed(dest_i) >>> w_shamt); w_alu_zn = 1'b1; end
          default: ;
        endcase
      end
      c_cls_logic: begin
        case (opc_i)
          c_opc_and: begin w_alu_res = dest_i & src_i; w_alu_zn = 1'b1; end
          c_opc_or:  begin w_alu_res = dest_i | src_i; w_alu_zn = 1'b1; end
          c_opc_xor: begin w_alu_res = dest_i ^ src_i; w_alu_zn = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (w_alu_zn) begin
      w_alu_flags[c_flag_z] = ~|w_alu_res;
      w_alu_flags[c_flag_n] = w_alu_res[WORD-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    wb_d        = wb_q;
    rd_num_d    = rd_num_q;
    rd_data_d   = rd_data_q;
    origaddr_d  = origaddr_q;
    flags_d     = flags_q;
    mwb_d       = mwb_q;
    mrd_d       = mrd_q;
    maddr_d     = maddr_q;
    w_mul_start = 1'b0;
    // a draining register with nothing new to write becomes a bubble
    if (w_load) begin
      v_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_mul_start = 1'b1;
          mwb_d       = wb_i;
          mrd_d       = rd_num_i;
          maddr_d     = origaddr_i;
          state_d     = BUSY;
        end else if (w_accept) begin
          v_d        = 1'b1;
          wb_d       = w_alu_wb;
          rd_num_d   = rd_num_i;
          rd_data_d  = w_alu_res;
          origaddr_d = origaddr_i;
          flags_d    = w_alu_flags;
        end
      end
      BUSY: begin
        if (w_mul_busy && w_mul_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (w_load) begin
          v_d               = 1'b1;
          wb_d              = mwb_q;
          rd_num_d          = mrd_q;
          rd_data_d         = w_mul_product;
          origaddr_d        = maddr_q;
          flags_d[c_flag_z] = ~|w_mul_product;
          flags_d[c_flag_n] = w_mul_product[WORD-1];
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      v_q        <= 1'b0;
      wb_q       <= 1'b0;
      rd_num_q   <= '0;
      rd_data_q  <= '0;
      origaddr_q <= '0;
      flags_q    <= '0;
      mwb_q      <= 1'b0;
      mrd_q      <= '0;
      maddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      wb_q       <= wb_d;
      rd_num_q   <= rd_num_d;
      rd_data_q  <= rd_data_d;
      origaddr_q <= origaddr_d;
      flags_q    <= flags_d;
      mwb_q      <= mwb_d;
      mrd_q      <= mrd_d;
      maddr_q    <= maddr_d;
    end
  end

  ex_mul_seq #(
    .WORD (WORD)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (dest_i),
    .b       (src_i),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  assign v_o        = v_q;
  assign wb_o       = wb_q;
  assign rd_num_o   = rd_num_q;
  assign rd_data_o  = rd_data_q;
  assign origaddr_o = origaddr_q;
  assign flags_o    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ex_stage_mc : scoreboard bench for ex_stage_mc with WORD = 8
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0, wb_i = 1'b0, stall_i = 1'b0;
  logic        stall_o, v_o, wb_o;
  logic [7:0]  src_i = '0, dest_i = '0, rd_data_o;
  logic [4:0]  rd_num_i = '0, rd_num_o;
  logic [3:0]  dopc_i = '0, flags_o;
  logic [2:0]  opc_i = '0;
  logic [31:0] origaddr_i = '0, origaddr_o;

  typedef struct packed {
    logic        wb;
    logic [4:0]  rd;
    logic [7:0]  data;
    logic [31:0] addr;
    logic [3:0]  flags;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mflags = 4'b0000;
  int         errors = 0;
  int         checks = 0;
  bit         rand_stall = 1'b0;
  bit         stall_dir  = 1'b0;

  ex_stage_mc #(.WORD(8), .W_RD(5), .W_ADDR(32), .W_FLAGS(4)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o),
    .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_num_i(rd_num_i),
    .dopc_i(dopc_i), .opc_i(opc_i), .origaddr_i(origaddr_i),
    .stall_i(stall_i), .v_o(v_o), .wb_o(wb_o), .rd_num_o(rd_num_o),
    .rd_data_o(rd_data_o), .origaddr_o(origaddr_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // WB back-pressure: directed value or random
  initial forever begin
    @(posedge clk);
    #2;
    stall_i = rand_stall ? ($urandom_range(0, 3) == 0) : stall_dir;
  end

  // Reference: flags {Z,N,C,V}, result = dest OP src, plain integer arithmetic
  function automatic void model(input logic [3:0] dopc, input logic [2:0] opc,
                                input logic [7:0] d, input logic [7:0] s,
                                input logic wbin, input logic [3:0] fin,
                                output logic [7:0] r, output logic wbo,
                                output logic [3:0] fout);
    int ud, us, sd, ss, full, sfull, amt;
    bit zn;
    ud = d; us = s; sd = $signed(d); ss = $signed(s); amt = s % 8;
    full = 0; zn = 0; fout = fin; wbo = wbin;
    case (dopc)
      4'b1000: if (opc <= 3'd2) begin
        full    = (opc == 3'd0) ? ud + us : ud - us;
        sfull   = (opc == 3'd0) ? sd + ss : sd - ss;
        fout[1] = (opc == 3'd0) ? (full > 255) : (ud >= us);
        fout[0] = (sfull > 127) || (sfull < -128);
        if (opc == 3'd2) wbo = 1'b0;
        zn = 1;
      end
      4'b0100: if (opc <= 3'd2) begin
        full = (opc == 3'd0) ? (ud << amt) : (opc == 3'd1) ? (ud >> amt) : (sd >>> amt);
        zn = 1;
      end
      4'b0010: if (opc <= 3'd2) begin
        full = (opc == 3'd0) ? (ud & us) : (opc == 3'd1) ? (ud | us) : (ud ^ us);
        zn = 1;
      end
      4'b0001: if (opc == 3'd0) begin
        full = ud * us;
        zn = 1;
      end
      default: ;
    endcase
    r = full[7:0];
    if (zn) begin
      fout[3] = (r == 8'h00);
      fout[2] = r[7];
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for acceptance, push its expected result
  task automatic issue(input logic [3:0] dopc, input logic [2:0] opc,
                       input logic [7:0] d, input logic [7:0] s, input logic wb,
                       input logic [4:0] rd, input logic [31:0] addr, input bit push);
    int         guard;
    exp_t       e;
    logic [7:0] r;
    logic       wbo;
    logic [3:0] nf;
    guard = 0;
    dopc_i = dopc; opc_i = opc; dest_i = d; src_i = s;
    wb_i = wb; rd_num_i = rd; origaddr_i = addr; v_i = 1'b1;
    @(negedge clk);
    while (stall_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (stall_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: stall_o=%b, required 0", stall_o);
    end else if (push) begin
      model(dopc, opc, d, s, wb, mflags, r, wbo, nf);
      mflags  = nf;
      e.wb    = wbo;
      e.rd    = rd;
      e.data  = r;
      e.addr  = addr;
      e.flags = nf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    v_i = 1'b0;
  endtask

  // Monitor: every presented output must match the head of the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst && v_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected output data=%h rd=%0d, required none", rd_data_o, rd_num_o);
      end else begin
        if ({wb_o, rd_num_o, rd_data_o, origaddr_o, flags_o} !== exp_q[0]) begin
          errors++;
          $display("FAIL scoreboard: got wb=%b rd=%0d data=%h addr=%h flags=%b, required wb=%b rd=%0d data=%h addr=%h flags=%b",
                   wb_o, rd_num_o, rd_data_o, origaddr_o, flags_o,
                   exp_q[0].wb, exp_q[0].rd, exp_q[0].data, exp_q[0].addr, exp_q[0].flags);
        end
        if (!stall_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int         k;
    logic [3:0] dp;
    logic [2:0] op;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {12'd0, v_o, wb_o, stall_o, rd_num_o, rd_data_o, origaddr_o, flags_o}, 64'd0);
    step();
    rst = 1'b1;

    issue(4'b1000, 3'd0, 8'h7F, 8'h01, 1'b1, 5'd3, 32'h100, 1'b1);
    @(negedge clk);
    chk("add_latency", {63'd0, v_o}, 64'd1);
    chk("add_result", {56'd0, rd_data_o}, 64'h80);
    chk("add_flags", {60'd0, flags_o}, 64'b0101);

    step();
    issue(4'b1000, 3'd2, 8'h05, 8'h05, 1'b1, 5'd4, 32'h104, 1'b1);
    @(negedge clk);
    chk("cmp_wb_flags", {59'd0, wb_o, flags_o}, {59'd0, 1'b0, 4'b1010});
    step();
    issue(4'b0010, 3'd1, 8'h00, 8'h00, 1'b1, 5'd5, 32'h108, 1'b1);
    @(negedge clk);
    chk("or_zero_keeps_c", {60'd0, flags_o}, 64'b1010);

    step();
    issue(4'b0001, 3'd0, 8'h0C, 8'h0B, 1'b1, 5'd6, 32'h10C, 1'b1);
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      if (j <= 8) chk("mul_busy_stall", {62'd0, stall_o, v_o}, 64'b10);
      else chk("mul_latency", {53'd0, stall_o, v_o, 1'b0, rd_data_o}, {53'd0, 2'b01, 1'b0, 8'h84});
    end
    step();

    issue(4'b0001, 3'd0, 8'h0C, 8'h0B, 1'b1, 5'd7, 32'h110, 1'b1);
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk);
      if (j >= 9 && j <= 12) chk("mul_held_by_stall", {55'd0, v_o, rd_data_o}, {55'd0, 1'b1, 8'h84});
      if (j == 9) chk("mul_stall_blocks_id", {63'd0, stall_o}, 64'd1);
      if (j == 13) chk("mul_drained_after_3", {63'd0, v_o}, 64'd0);
      step();
      if (j == 8) stall_dir = 1'b1;
      if (j == 11) stall_dir = 1'b0;
    end

    stall_dir = 1'b1;
    issue(4'b0100, 3'd2, 8'hF0, 8'h02, 1'b1, 5'd8, 32'h114, 1'b1);
    @(negedge clk);
    chk("sra_into_empty", {54'd0, v_o, stall_o, rd_data_o}, {54'd0, 2'b11, 8'hFC});
    repeat (2) begin
      @(negedge clk);
      chk("stall_o_while_full", {63'd0, stall_o}, 64'd1);
    end
    step();
    stall_dir = 1'b0;
    issue(4'b0010, 3'd2, 8'h5A, 8'hFF, 1'b1, 5'd9, 32'h118, 1'b1);
    @(negedge clk);
    chk("xor_after_release", {56'd0, rd_data_o}, 64'hA5);

    repeat (3) step();
    issue(4'b0001, 3'd0, 8'h33, 8'h44, 1'b1, 5'd10, 32'h11C, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_busy", {12'd0, v_o, wb_o, stall_o, rd_num_o, rd_data_o, origaddr_o, flags_o}, 64'd0);
    step();
    rst = 1'b1;
    mflags = 4'b0000;
    exp_q.delete();
    @(negedge clk);
    chk("post_reset_idle", {62'd0, stall_o, v_o}, 64'd0);
    step();
    issue(4'b1000, 3'd0, 8'h01, 8'h01, 1'b1, 5'd11, 32'h120, 1'b1);
    @(negedge clk);
    chk("add_after_reset", {56'd0, rd_data_o}, 64'h02);

    step();
    issue(4'b0110, 3'd0, 8'h12, 8'h34, 1'b1, 5'd12, 32'h124, 1'b1);
    @(negedge clk);
    chk("multihot_dopc", {51'd0, v_o, rd_data_o, flags_o}, {51'd0, 1'b1, 8'h00, 4'b0000});
    step();

    rand_stall = 1'b1;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    dp = 4'b1000;
        2, 3:    dp = 4'b0100;
        4, 5:    dp = 4'b0010;
        6, 7:    dp = 4'b0001;
        default: dp = 4'($urandom_range(0, 15));
      endcase
      op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      issue(dp, op, 8'($urandom), 8'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    rand_stall = 1'b0;
    stall_dir  = 1'b0;
    for (int g = 0; g < 100 && exp_q.size() > 0; g++) step();
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised successor of the single-cycle execute stage. It sits between ID and WB, evaluates integer, shift and logic ops in one cycle, and evaluates multiply as a multi-cycle iterative op. It holds a flags register and drives WB through a valid/stall pipeline register. Unlike the previous stage, a bubble in the output register is always refilled, so no instruction is lost while WB is stalled.

## Interface
- WORD, 32: datapath width; must be ≥ 4 and a power of two.
- W_RD, 5: destination register number width.
- W_ADDR, 32: instruction address width.
- W_FLAGS, 4: flags width, fixed bit order {Z,N,C,V} (bit 3 = Z).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- v_i  in  1  ID holds a valid op.
- stall_o  out  1  ID must hold all inputs this cycle.
- src_i, dest_i  in  WORD  operands; result = dest_i OP src_i.
- wb_i  in  1  op writes rd.
- rd_num_i  in  W_RD  destination register.
- dopc_i  in  4  one-hot class: [3] inte, [2] shift, [1] logic, [0] mul.
- opc_i  in  3  sub-op within the class.
- origaddr_i  in  W_ADDR  carried through to origaddr_o.
- stall_i  in  1  WB cannot accept this cycle.
- v_o, wb_o  out  1  registered valid and writeback flags.
- rd_num_o  out  W_RD  registered destination register.
- rd_data_o  out  WORD  registered result.
- origaddr_o  out  W_ADDR  registered instruction address.
- flags_o  out  W_FLAGS  current flags register.

## Operation
- Sub-ops:
  - inte: 0 add, 1 sub (dest−src), 2 cmp. cmp computes sub, sets flags, and forces wb_o = 0.
  - shift: 0 sll, 1 srl, 2 sra. Shift amount is src_i[log2(WORD)−1:0].
  - logic: 0 and, 1 or, 2 xor.
  - mul: 0 = low WORD bits of the unsigned product.
  - Undefined opc gives result 0 and leaves flags unchanged.
- Flags:
  - inte updates Z, N, C and V. C is carry-out for add and no-borrow for sub/cmp; V is signed overflow.
  - shift, logic and mul update Z and N only; C and V are held.
  - dopc_i zero or multi-hot: result 0, flags unchanged, op still passes with v_o.
- Acceptance:
  - accept = v_i & ~stall_o.
  - load = ~v_r | ~stall_i (the output register is empty or draining).
  - stall_o = (fsm != IDLE) | (v_r & stall_i).
- FSM:
  - IDLE: a non-mul accept with load writes the output register. A mul accept latches the operands, rd_num, wb and origaddr, clears the counter, and goes to BUSY.
  - BUSY: one shift-add step per cycle. When the counter reaches WORD−1, go to DONE.
  - DONE: when load is high, write the product and Z/N into the output register with v_r = 1, then go to IDLE.
- When the FSM is in IDLE and load is high but nothing is accepted, v_r ← 0 (bubble).
- Reset: all outputs and registers go to 0, FSM goes to IDLE. A reset during BUSY or DONE discards the product.

## Timing
- Single-cycle ops: accepted at edge N, outputs visible after edge N. Latency is 1.
- mul: accepted at edge N; v_o rises after edge N+WORD+1 if stall_i stays low.
- stall_o is high for the whole of BUSY and DONE.
- Back-to-back single-cycle ops sustain 1 per cycle while stall_i = 0.
- With stall_i = 1 and v_r = 1, the outputs and flags_o hold exactly.
- With stall_i = 1 and v_r = 0, one op is accepted into the empty output register.
- Flags are written on the same edge as the result, so they are visible to the next op one cycle later.

## Structure
- Package ex_pkg holds:
  - DOPC bit indices and OPC codes for every class.
  - Flag bit positions.
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module ex_mul_seq is the iterative multiplier, with ports start, a, b, busy, done and product. It owns the counter and the accumulator.
- The single-cycle ALU is combinational inside ex_stage_mc.

## Test plan
All scenarios use WORD = 8.
- Reset, then add dest = 0x7F, src = 0x01 → rd_data_o = 0x80; flags Z = 0, N = 1, C = 0, V = 1; v_o = 1 one cycle after accept.
- cmp dest = 0x05, src = 0x05 → wb_o = 0, Z = 1, C = 1. A following or of 0x00 and 0x00 gives Z = 1 with C still 1.
- mul dest = 0x0C, src = 0x0B → rd_data_o = 0x84 with v_o high 9 cycles after accept; stall_o high for cycles 1–9. Repeat with stall_i held high for 3 cycles at completion: the result is delayed by exactly 3 cycles.
- stall_i = 1 with v_r = 0, present sra 0xF0 by 2 → it is accepted and rd_data_o = 0xFC. The next op then sees stall_o = 1 until stall_i falls.
- Assert rst for one cycle during BUSY of a mul → all outputs 0, FSM IDLE, stall_o = 0. A following add 0x01 + 0x01 gives 0x02.
- dopc_i = 4'b0110 → v_o = 1, rd_data_o = 0, flags unchanged.
